// File: rtl/cla_pkg.sv
// Shared types and configuration helpers for the pipelined carry-look-ahead adder.
// The stage payload is sized for the widest supported operand; unused upper bits stay zero.
package cla_pkg;

  localparam int CLA_WIDTH     = 32;
  localparam int CLA_BLOCK     = 8;
  localparam int NBLK          = CLA_WIDTH / CLA_BLOCK;
  localparam int CLA_MAX_WIDTH = 128;

  typedef struct packed {
    logic                     valid;
    logic                     carry;
    logic                     ovf;
    logic [CLA_MAX_WIDTH-1:0] psum;
    logic [CLA_MAX_WIDTH-1:0] aop;
    logic [CLA_MAX_WIDTH-1:0] bop;
  } cla_stage_t;

  function automatic bit cla_cfg_ok(input int width, input int block);
    return (block > 0) && (width >= block) && ((width % block) == 0) &&
           (width <= CLA_MAX_WIDTH);
  endfunction

  function automatic int cla_nblk(input int width, input int block);
    return (block > 0) ? (width / block) : NBLK;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational BLOCK-bit carry-look-ahead slice; also exposes the carry into its MSB
// so the last stage can derive signed overflow.
module cla_slice
  import cla_pkg::*;
#(
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] g_s;
  logic [BLOCK-1:0] p_s;
  logic [BLOCK:0]   c_s;
  logic             term_s;
  logic             prop_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Each carry is a flat sum of generate terms gated by propagate chains, not a ripple.
  always_comb begin
    c_s    = '0;
    term_s = 1'b0;
    prop_s = 1'b0;
    c_s[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      term_s = g_s[i];
      prop_s = p_s[i];
      for (int j = i - 1; j >= 0; j--) begin
        term_s = term_s | (prop_s & g_s[j]);
        prop_s = prop_s & p_s[j];
      end
      c_s[i+1] = term_s | (prop_s & cin);
    end
  end

  assign sum   = p_s ^ c_s[BLOCK-1:0];
  assign cout  = c_s[BLOCK];
  assign c_msb = c_s[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one BLOCK-bit slice per stage, valid/ready handshake,
// the whole pipeline advances together and freezes while the result is backpressured.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSTG = cla_nblk(WIDTH, BLOCK);

  generate
    if (!cla_cfg_ok(WIDTH, BLOCK)) begin : g_bad_cfg
      $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK, >= BLOCK and <= CLA_MAX_WIDTH");
    end
  endgenerate

  logic             adv_s;
  logic [WIDTH-1:0] bx_s;
  logic             cx_s;
  cla_stage_t       fresh_s;
  cla_stage_t       src_s  [NSTG];
  cla_stage_t       nxt_s  [NSTG];
  cla_stage_t       pipe_r [NSTG];

  logic [BLOCK-1:0] sl_a_s    [NSTG];
  logic [BLOCK-1:0] sl_b_s    [NSTG];
  logic [BLOCK-1:0] sl_sum_s  [NSTG];
  logic             sl_cin_s  [NSTG];
  logic             sl_cout_s [NSTG];
  logic             sl_cmsb_s [NSTG];

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;
  assign bx_s     = sub ? ~b : b;
  assign cx_s     = sub ? 1'b1 : c_in;

  // Gather each stage's source payload and cut out the operand slice it works on.
  always_comb begin
    fresh_s                 = '0;
    fresh_s.valid           = in_valid;
    fresh_s.carry           = cx_s;
    fresh_s.aop[WIDTH-1:0]  = a;
    fresh_s.bop[WIDTH-1:0]  = bx_s;
    src_s[0]                = fresh_s;
    for (int k = 1; k < NSTG; k++) begin
      src_s[k] = pipe_r[k-1];
    end
    for (int k = 0; k < NSTG; k++) begin
      sl_a_s[k]   = src_s[k].aop[k*BLOCK +: BLOCK];
      sl_b_s[k]   = src_s[k].bop[k*BLOCK +: BLOCK];
      sl_cin_s[k] = src_s[k].carry;
    end
  end

  generate
    for (genvar k = 0; k < NSTG; k++) begin : g_stage
      cla_slice #(
        .BLOCK (BLOCK)
      ) u_slice (
        .a     (sl_a_s[k]),
        .b     (sl_b_s[k]),
        .cin   (sl_cin_s[k]),
        .sum   (sl_sum_s[k]),
        .cout  (sl_cout_s[k]),
        .c_msb (sl_cmsb_s[k])
      );
    end
  endgenerate

  // Merge each slice result into its payload; finished sums and pending operands ride along.
  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      nxt_s[k]                          = src_s[k];
      nxt_s[k].psum[k*BLOCK +: BLOCK]   = sl_sum_s[k];
      nxt_s[k].carry                    = sl_cout_s[k];
      nxt_s[k].ovf                      = sl_cmsb_s[k] ^ sl_cout_s[k];
    end
  end

  // Pipeline registers: clear on reset, shift together on advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        pipe_r[k] <= '0;
      end
    end else if (adv_s) begin
      for (int k = 0; k < NSTG; k++) begin
        pipe_r[k] <= nxt_s[k];
      end
    end
  end

  assign out_valid = pipe_r[NSTG-1].valid;
  assign sum       = pipe_r[NSTG-1].psum[WIDTH-1:0];
  assign c_out     = pipe_r[NSTG-1].carry;
  assign ovf       = pipe_r[NSTG-1].ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed vectors plus random stream/backpressure
// on a 32/8 instance, and a short latency-1 check on an 8/8 instance.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic [31:0] s;
    logic        c;
    logic        o;
  } vec_t;

  localparam vec_t DIR_V [12] = '{
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
    '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1},
    '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0},
    '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0},
    '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1},
    '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0},
    '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0},
    '{32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0},
    '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1}
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [31:0] a, b, sum;
  logic        in_valid8, in_ready8, c_in8, sub8, out_valid8, out_ready8, c_out8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q [$];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .ovf(ovf)
  );

  pipelined_cla_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .c_in(c_in8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
    .c_out(c_out8), .ovf(ovf8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                     input logic rci, input logic rsub);
    logic [31:0] bx;
    logic [32:0] t;
    exp_t        e;
    bx   = rsub ? ~rb : rb;
    t    = {1'b0, ra} + {1'b0, bx} + {32'd0, (rsub ? 1'b1 : rci)};
    e.s  = t[31:0];
    e.c  = t[32];
    e.o  = (ra[31] == bx[31]) && (t[31] != ra[31]);
    return e;
  endfunction

  // One cycle: drive after the rising edge, decide acceptance at the falling edge.
  task automatic drive(input logic v, input logic [31:0] va, input logic [31:0] vb,
                       input logic vci, input logic vsub, input logic ordy, input exp_t e);
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = va;
    b         = vb;
    c_in      = vci;
    sub       = vsub;
    out_ready = ordy;
    @(negedge clk);
    if (v && in_ready) sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb_q.size() != 0; n++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, '0);
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: handshake rule, stall stability and in-order result checking.
  initial begin
    exp_t        e;
    logic        stall_q = 1'b0;
    logic [33:0] hold_q  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready_rule", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
        if (stall_q) begin
          chk("stall_hold", {30'd0, out_valid, c_out, ovf, sum}, {30'd0, 1'b1, hold_q});
        end
        if (out_valid && out_ready) begin
          chk("result_expected", {63'd0, sb_q.size() != 0}, 64'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sum", {32'd0, sum}, {32'd0, e.s});
            chk("c_out", {63'd0, c_out}, {63'd0, e.c});
            chk("ovf", {63'd0, ovf}, {63'd0, e.o});
          end
        end
      end
      stall_q = !rst && out_valid && !out_ready;
      hold_q  = {c_out, ovf, sum};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rci, rsub, rv, rr;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_c_out", {63'd0, c_out}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid8", {63'd0, out_valid8}, 64'd0);

    // Directed vectors back to back.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, DIR_V[i].a, DIR_V[i].b, DIR_V[i].ci, DIR_V[i].sb, 1'b1,
            '{s: DIR_V[i].s, c: DIR_V[i].c, o: DIR_V[i].o});
    end
    drain();

    // Full-rate stream: out_valid must rise at cycle 4 and stay high for 100 cycles.
    for (int n = 0; n < 104; n++) begin
      if (n < 100) begin
        ra = $urandom; rb = $urandom; rci = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
        drive(1'b1, ra, rb, rci, rsub, 1'b1, ref_model(ra, rb, rci, rsub));
      end else begin
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, '0);
      end
      chk("stream_out_valid", {63'd0, out_valid}, {63'd0, (n >= 4)});
    end
    drain();

    // Random valid and backpressure.
    for (int n = 0; n < 300; n++) begin
      ra = $urandom; rb = $urandom; rci = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
      drive(rv, ra, rb, rci, rsub, rr, ref_model(ra, rb, rci, rsub));
    end
    drain();

    // Reset with three operations in flight: nothing may come out.
    for (int n = 0; n < 3; n++) begin
      ra = $urandom; rb = $urandom;
      drive(1'b1, ra, rb, 1'b0, 1'b0, 1'b1, ref_model(ra, rb, 1'b0, 1'b0));
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    for (int n = 0; n < 6; n++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, '0);
      chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);
    end

    // WIDTH=8, BLOCK=8: single stage, one-cycle latency.
    @(posedge clk);
    #1;
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c_in8 = 1'b1; sub8 = 1'b0;
    @(negedge clk);
    chk("w8_in_ready", {63'd0, in_ready8}, 64'd1);
    @(posedge clk);
    #1;
    a8 = 8'h7F; b8 = 8'h01; c_in8 = 1'b0;
    @(negedge clk);
    chk("w8_valid1", {63'd0, out_valid8}, 64'd1);
    chk("w8_sum1", {56'd0, sum8}, 64'h01);
    chk("w8_c_out1", {63'd0, c_out8}, 64'd1);
    chk("w8_ovf1", {63'd0, ovf8}, 64'd0);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    chk("w8_valid2", {63'd0, out_valid8}, 64'd1);
    chk("w8_sum2", {56'd0, sum8}, 64'h80);
    chk("w8_c_out2", {63'd0, c_out8}, 64'd0);
    chk("w8_ovf2", {63'd0, ovf8}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("w8_bubble", {63'd0, out_valid8}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-look-ahead adder/subtractor with a valid/ready handshake. It splits a WIDTH-bit operation into BLOCK-bit carry-look-ahead slices and gives each slice one pipeline stage, so throughput is one operation per cycle at any width. It sits between operand producers, such as the datapath register stage, and result consumers that may apply backpressure.

## Interface
Parameters:
- WIDTH, default 32: operand width; must be a multiple of BLOCK and at least BLOCK.
- BLOCK, default 8: slice width; number of stages NBLK = WIDTH/BLOCK.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used only when sub=0.
- sub  input  1  1 selects a - b; 0 selects a + b + c_in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of the MSB (for sub: 1 means no borrow).
- ovf  output  1  signed overflow.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Effective operands:
  - bx = sub ? ~b : b.
  - cx = sub ? 1 : c_in.
  - The result is a + bx + cx, modulo 2^WIDTH, with c_out the carry out of bit WIDTH-1.
- Stage k (0..NBLK-1):
  - Adds slice k of a and bx with the carry registered by stage k-1 (cx for stage 0).
  - Uses a BLOCK-bit look-ahead slice built from generate/propagate terms.
  - Registers the slice sum, the slice carry-out and a valid bit.
- Skew registers:
  - Upper operand slices are delayed so that they reach stage k together with their carry.
  - Completed lower sum slices are delayed so that all slices emerge aligned at the last stage.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Advance enable: adv = !out_valid || out_ready.
  - When adv=1, every stage shifts one step.
  - When adv=0, every pipeline register holds.
- in_ready = adv, a combinational path from out_ready.
- A cycle with in_valid=0 and adv=1 inserts a bubble (valid=0). Bubbles are not compressed.
- sum, c_out and ovf are meaningful only while out_valid=1. They hold stable while out_valid && !out_ready.

## Timing
- Reset:
  - All valid bits, out_valid, sum, c_out and ovf are 0.
  - in_ready reads 1 in the first cycle after reset.
  - Reset has priority over any transfer.
  - Reset mid-operation discards every in-flight operation with no output.
- Latency: an operation accepted at edge t raises out_valid after edge t+NBLK-1, i.e. it is visible in the cycle following edge t+NBLK-1.
  - NBLK=1 gives 1-cycle latency, behaving as a registered CLA.
- Throughput is 1 operation per cycle while out_ready=1.
- Stall while out_valid=1 and out_ready=0:
  - in_ready=0 in the same cycle.
  - No register changes.
  - The stall causes no loss and no duplication of results.
- Simultaneous accept and emit in one cycle are permitted. Both occur on the same edge.
- Ordering is strictly FIFO.

## Structure
- Shared package cla_pkg holds:
  - the elaboration check that WIDTH % BLOCK == 0 and WIDTH ≥ BLOCK;
  - a localparam NBLK;
  - a packed struct for a stage's registered payload (valid, carry, partial sum, skewed operands).
- One sub-module, cla_slice: combinational BLOCK-bit look-ahead adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and the carry into its MSB, needed for ovf.
  - Instantiated NBLK times in a generate loop.

## Test plan
The bench uses WIDTH=32 and BLOCK=8 (latency 4) unless stated.
- Ripple through all slices: a=0xFFFFFFFF, b=0x00000001, sub=0, c_in=0 → four cycles later sum=0x00000000, c_out=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, ovf=1, c_out=0. With sub=1, a=0x80000000, b=1 → sum=0x7FFFFFFF, ovf=1, c_out=1.
- Subtract with borrow: sub=1, a=5, b=7, c_in=1 → sum=0xFFFFFFFE, c_out=0 (c_in ignored).
- Back-to-back stream of 100 random operations with out_ready=1 → out_valid continuously high from cycle 4 onward, results match the reference model in order.
- Backpressure: random out_ready (50%) with random in_valid → no lost or duplicated results, in_ready equal to !(out_valid && !out_ready) every cycle, outputs stable during stall.
- Reset mid-stream with 3 operations in flight → out_valid=0 from the next cycle and no stale result emitted. Repeat with WIDTH=8, BLOCK=8: latency 1, 0xFF+0x01+c_in=1 → sum=0x01, c_out=1.
